// File: rtl/cache_page_client.sv
// Page-allocation client: requests pages from an external allocator with bounded
// retries, tracks granted pages in a FIFO and releases them oldest-first.
module cache_page_client #(
  parameter  int PAGES     = 32,
  parameter  int RETRY_MAX = 15,
  localparam int AWIDTH    = $clog2(PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic              alloc_done,
  output logic              alloc_fail,
  output logic [AWIDTH-1:0] alloc_id,
  input  logic              free_valid,
  output logic              free_ready,
  output logic [AWIDTH-1:0] free_id,
  output logic              page_req,
  input  logic              page_grant,
  input  logic [AWIDTH-1:0] page_id,
  output logic              page_clr,
  output logic [AWIDTH-1:0] page_id_clr,
  output logic [AWIDTH:0]   held_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [AWIDTH:0]   FULL       = (AWIDTH+1)'(PAGES);
  localparam logic [AWIDTH:0]   CNT_ONE    = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_LAST   = AWIDTH'(PAGES-1);
  localparam logic [AWIDTH-1:0] PTR_ONE    = AWIDTH'(1);
  localparam logic [7:0]        RETRY_LAST = 8'(RETRY_MAX-1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        retry_q, retry_d;
  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [AWIDTH:0]   count_q;
  logic [AWIDTH-1:0] mem_q [PAGES];
  logic              page_req_q, page_clr_q, alloc_done_q, alloc_fail_q;
  logic [AWIDTH-1:0] alloc_id_q, page_id_clr_q;
  logic              push, pop, done_d, fail_d;

  assign alloc_ready = (state_q == S_IDLE) && (count_q < FULL);
  assign free_ready  = (count_q != '0);
  assign free_id     = mem_q[rptr_q];
  assign pop         = free_valid && free_ready;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    push    = 1'b0;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      S_IDLE: if (alloc_valid && alloc_ready) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (page_grant) begin
          push    = 1'b1;
          done_d  = 1'b1;
          retry_d = '0;
          state_d = S_IDLE;
        end else if (retry_q >= RETRY_LAST) begin
          fail_d  = 1'b1;
          retry_d = '0;
          state_d = S_IDLE;
        end else begin
          retry_d = retry_q + 8'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      retry_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      page_req_q    <= 1'b0;
      page_clr_q    <= 1'b0;
      alloc_done_q  <= 1'b0;
      alloc_fail_q  <= 1'b0;
      alloc_id_q    <= '0;
      page_id_clr_q <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      // page_req is high for the whole single-cycle REQ state
      page_req_q   <= (state_d == S_REQ);
      alloc_done_q <= done_d;
      alloc_fail_q <= fail_d;
      page_clr_q   <= pop;
      if (push) begin
        alloc_id_q <= page_id;
        wptr_q     <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_ONE;
      end
      if (pop) begin
        page_id_clr_q <= mem_q[rptr_q];
        rptr_q        <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= page_id;
  end

  assign page_req    = page_req_q;
  assign page_clr    = page_clr_q;
  assign page_id_clr = page_id_clr_q;
  assign alloc_done  = alloc_done_q;
  assign alloc_fail  = alloc_fail_q;
  assign alloc_id    = alloc_id_q;
  assign held_count  = count_q;

endmodule

// File: tb/tb_cache_page_client.sv
// Scoreboard bench for cache_page_client: an allocator/reference model predicts
// allocation results, releases and occupancy; a negedge monitor compares.
module tb_cache_page_client;
  localparam int PAGES     = 8;
  localparam int RETRY_MAX = 4;
  localparam int AW        = $clog2(PAGES);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0, free_valid = 1'b0;
  logic          alloc_ready, alloc_done, alloc_fail, free_ready, page_req, page_clr;
  logic [AW-1:0] alloc_id, free_id, page_id_clr;
  logic          page_grant = 1'b0;
  logic [AW-1:0] page_id = '0;
  logic [AW:0]   held_count;

  always #5 clk = ~clk;

  cache_page_client #(.PAGES(PAGES), .RETRY_MAX(RETRY_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_done(alloc_done),
    .alloc_fail(alloc_fail), .alloc_id(alloc_id),
    .free_valid(free_valid), .free_ready(free_ready), .free_id(free_id),
    .page_req(page_req), .page_grant(page_grant), .page_id(page_id),
    .page_clr(page_clr), .page_id_clr(page_id_clr), .held_count(held_count)
  );

  typedef struct { bit ok; int id; } res_t;
  res_t exp_q[$];
  int   clr_q[$];
  int   held[$];
  int   pool[$];
  bit   busy = 0, resp_pending = 0, force_grant = 0;
  int   misses = 0, deny_pct = 0, reqs = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic flag(input string name, input string act, input string req);
    checks++;
    failures++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  function automatic void model_reset();
    held.delete();
    exp_q.delete();
    clr_q.delete();
    pool.delete();
    for (int i = 0; i < PAGES; i++) pool.push_back(i);
    busy = 0;
    resp_pending = 0;
    misses = 0;
  endfunction

  // Allocator + reference model: snapshot inputs just before each edge, update at the edge.
  initial begin : model
    bit s_req, s_grant, s_av, s_fv, pre_busy;
    int s_id, pre_size, v;
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      s_req = page_req; s_grant = page_grant; s_id = int'(page_id);
      s_av = alloc_valid; s_fv = free_valid;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        pre_size = held.size();
        pre_busy = busy;
        if (s_fv && pre_size > 0) begin
          v = held.pop_front();
          clr_q.push_back(v);
          pool.push_back(v);
        end
        if (resp_pending) begin
          if (s_grant) begin
            exp_q.push_back('{1'b1, s_id});
            held.push_back(s_id);
            misses = 0;
            busy = 0;
          end else begin
            misses++;
            if (misses >= RETRY_MAX) begin
              exp_q.push_back('{1'b0, 0});
              misses = 0;
              busy = 0;
            end
          end
        end
        if (s_av && !pre_busy && pre_size < PAGES) busy = 1;
        resp_pending = s_req;
      end
      #1;
      if (resp_pending && pool.size() > 0 && $urandom_range(99) >= deny_pct) begin
        page_id = AW'(pool.pop_front());
        page_grant = 1'b1;
      end else begin
        page_grant = force_grant;
      end
    end
  end

  initial begin : monitor
    res_t e;
    int v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_free_ready", free_ready, 0);
        chk("rst_held_count", held_count, 0);
        chk("rst_page_req", page_req, 0);
        chk("rst_page_clr", page_clr, 0);
        chk("rst_page_id_clr", page_id_clr, 0);
        chk("rst_alloc_done", alloc_done, 0);
        chk("rst_alloc_fail", alloc_fail, 0);
        chk("rst_alloc_id", alloc_id, 0);
      end else begin
        chk("held_count", held_count, held.size());
        chk("alloc_ready", alloc_ready, int'(!busy && held.size() < PAGES));
        chk("free_ready", free_ready, int'(held.size() != 0));
        if (held.size() > 0) chk("free_id", free_id, held[0]);
        if (page_req) begin
          reqs++;
          chk("page_req_without_alloc", busy, 1);
        end
        if (alloc_done || alloc_fail) begin
          if (exp_q.size() == 0) chk("unexpected_result", {alloc_done, alloc_fail}, 0);
          else begin
            e = exp_q.pop_front();
            chk("alloc_done", alloc_done, e.ok);
            chk("alloc_fail", alloc_fail, !e.ok);
            if (e.ok) chk("alloc_id", alloc_id, e.id);
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          flag("result_missing", "none", e.ok ? "alloc_done" : "alloc_fail");
        end
        if (page_clr) begin
          if (clr_q.size() == 0) chk("unexpected_page_clr", page_clr, 0);
          else begin
            v = clr_q.pop_front();
            chk("page_id_clr", page_id_clr, v);
          end
        end else if (clr_q.size() > 0) begin
          v = clr_q.pop_front();
          flag("page_clr_missing", "none", "page_clr");
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic alloc_one();
    bit acc;
    int n;
    n = 0;
    alloc_valid = 1'b1;
    do begin
      acc = alloc_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 100);
    alloc_valid = 1'b0;
    if (!acc) flag("alloc_accept_timeout", "no_accept", "accept");
  endtask

  task automatic free_one();
    bit acc;
    int n;
    n = 0;
    free_valid = 1'b1;
    do begin
      acc = free_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 100);
    free_valid = 1'b0;
    if (!acc) flag("free_accept_timeout", "no_accept", "accept");
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while ((busy || exp_q.size() != 0 || clr_q.size() != 0) && n < 300);
    if (busy || exp_q.size() != 0 || clr_q.size() != 0) flag("quiet_timeout", "pending", "idle");
  endtask

  initial begin : stim
    int n;
    do_reset();

    // single allocation, id 0
    alloc_one();
    wait_quiet();
    chk("single_held", held_count, 1);

    // three allocations then three in-order frees
    do_reset();
    repeat (3) begin alloc_one(); wait_quiet(); end
    repeat (3) free_one();
    wait_quiet();
    chk("drain_held", held_count, 0);
    chk("drain_free_ready", free_ready, 0);

    // allocator never grants
    do_reset();
    deny_pct = 100;
    reqs = 0;
    alloc_one();
    wait_quiet();
    chk("retry_req_count", reqs, RETRY_MAX);
    deny_pct = 0;

    // fill, free one, re-grant the freed id across the pointer wrap
    do_reset();
    for (int i = 0; i < PAGES; i++) begin alloc_one(); wait_quiet(); end
    chk("full_held", held_count, PAGES);
    chk("full_alloc_ready", alloc_ready, 0);
    free_one();
    wait_quiet();
    chk("after_free_ready", alloc_ready, 1);
    alloc_one();
    wait_quiet();
    chk("refill_held", held_count, PAGES);

    // free in the same cycle as a grant push
    do_reset();
    repeat (2) begin alloc_one(); wait_quiet(); end
    alloc_one();
    n = 0;
    while (!page_grant && n < 50) begin @(posedge clk); #2; n++; end
    if (!page_grant) flag("grant_timeout", "no_grant", "grant");
    free_valid = 1'b1;
    @(posedge clk);
    #2 free_valid = 1'b0;
    chk("conc_page_clr", page_clr, 1);
    chk("conc_alloc_done", alloc_done, 1);
    chk("conc_held", held_count, 2);
    wait_quiet();

    // reset during WAIT followed by a stray grant
    do_reset();
    deny_pct = 100;
    alloc_one();
    n = 0;
    while (!page_req && n < 50) begin @(posedge clk); #2; n++; end
    if (!page_req) flag("req_timeout", "no_req", "page_req");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    force_grant = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("post_rst_done", alloc_done, 0);
    chk("post_rst_fail", alloc_fail, 0);
    chk("post_rst_held", held_count, 0);
    chk("post_rst_req", page_req, 0);
    force_grant = 1'b0;
    deny_pct = 0;
    @(posedge clk);
    #2;

    // randomized traffic at several grant/free rates
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      deny_pct = (ph == 0) ? 30 : (ph == 1) ? 75 : 10;
      repeat (1500) begin
        @(posedge clk);
        #2;
        alloc_valid = ($urandom_range(1) == 1);
        free_valid  = ($urandom_range(ph == 2 ? 7 : 3) == 0);
      end
    end
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    wait_quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_page_client.md
CACHE_PAGE_CLIENT -- requirements
Module: cache_page_client

Interface
REQ-001 Parameter: PAGES, 32, number of pages managed by the page allocator.
REQ-002 Parameter: AWIDTH, $clog2(PAGES), page id width; SHALL be treated as a localparam.
REQ-003 Parameter: RETRY_MAX, 15, maximum number of consecutive ungranted page requests before an allocation fails; range 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 alloc_valid  input  1  upstream requests one page.
REQ-007 alloc_ready  output  1  block accepts an allocation command.
REQ-008 alloc_done  output  1  one-cycle pulse: allocation succeeded.
REQ-009 alloc_fail  output  1  one-cycle pulse: allocation abandoned after RETRY_MAX misses.
REQ-010 alloc_id  output  AWIDTH  page id granted; valid only with alloc_done.
REQ-011 free_valid  input  1  upstream releases the oldest held page.
REQ-012 free_ready  output  1  at least one page is held.
REQ-013 free_id  output  AWIDTH  id of the page being released; valid with free_ready.
REQ-014 page_req  output  1  page request to the allocator.
REQ-015 page_grant  input  1  allocator grant; arrives one cycle after page_req is sampled.
REQ-016 page_id  input  AWIDTH  allocator page id; valid when page_grant=1.
REQ-017 page_clr  output  1  page release strobe to the allocator.
REQ-018 page_id_clr  output  AWIDTH  page id to release; valid with page_clr.
REQ-019 held_count  output  AWIDTH+1  number of pages currently held (0..PAGES).

Function
REQ-020 The allocation FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-021 In IDLE: alloc_ready=1 iff held_count<PAGES; an alloc_valid&alloc_ready transfer SHALL move the FSM to REQ.
REQ-022 In REQ: the FSM SHALL assert page_req for exactly one cycle and move to WAIT.
REQ-023 In REQ and WAIT: alloc_ready SHALL be 0, so only one allocation is outstanding at a time.
REQ-024 In WAIT with page_grant=1: the block SHALL push page_id into the held FIFO, pulse alloc_done with alloc_id=page_id on the next cycle, clear the retry counter and return to IDLE.
REQ-025 In WAIT with page_grant=0 and retry count<RETRY_MAX-1: the block SHALL increment the retry counter and return to REQ.
REQ-026 In WAIT with page_grant=0 and retry count=RETRY_MAX-1: the block SHALL pulse alloc_fail on the next cycle, clear the retry counter and return to IDLE.
REQ-027 page_grant SHALL be ignored outside WAIT.
REQ-028 Held FIFO: PAGES entries of AWIDTH bits, in grant order, with read/write pointers that wrap modulo PAGES.
REQ-029 free_ready SHALL equal (held_count!=0).
REQ-030 free_id SHALL equal the FIFO head.
REQ-031 A free_valid&free_ready transfer SHALL pop the head and drive page_clr=1 with page_id_clr=that id on the next cycle, for one cycle only.
REQ-032 free_valid while free_ready=0 SHALL be ignored and SHALL NOT produce page_clr.
REQ-033 A push (grant) and a pop (free) in the same cycle SHALL both complete, leaving held_count unchanged.
REQ-034 A page released in cycle t MAY be re-granted; the block SHALL NOT filter duplicate ids.
REQ-035 held_count SHALL never exceed PAGES; when held_count=PAGES, alloc_ready SHALL be 0.
REQ-036 page_req, page_clr, page_id_clr, alloc_done, alloc_fail and alloc_id SHALL be registered outputs.

Reset
REQ-037 While rst_n=0: FSM=IDLE; FIFO pointers, held_count and retry counter=0; page_req, page_clr, alloc_done and alloc_fail=0; alloc_id and page_id_clr=0.
REQ-038 Reset asserted mid-allocation SHALL abandon the request, with no alloc_done or alloc_fail pulse; a grant arriving after reset SHALL be ignored.
REQ-039 Held pages SHALL be forgotten on reset; the allocator SHALL be reset together with this block.

Verification
REQ-040 Reset release, one alloc_valid, allocator grants id 0 -> page_req pulses for one cycle; alloc_done plus alloc_id=0 appear 2 cycles after page_req; held_count=1.
REQ-041 Allocate 3 pages (ids 0,1,2), then 3 frees -> page_clr pulses with page_id_clr=0,1,2 in order; held_count returns to 0; free_ready=0.
REQ-042 RETRY_MAX=4, allocator always returns page_grant=0 -> exactly 4 page_req pulses, one alloc_fail pulse, no alloc_done.
REQ-043 PAGES allocations -> held_count=PAGES and alloc_ready=0; one free -> alloc_ready=1; next grant reuses the freed id and the FIFO pointer wraps.
REQ-044 Free transfer in the same cycle as a grant push -> page_clr issued, alloc_done issued, held_count unchanged.
REQ-045 rst_n dropped during WAIT, followed by page_grant=1 -> no alloc_done; all outputs are at reset values.
